alu_cond_ctrl_unit: RTL and testbench

ALU_COND_CTRL_UNIT -- requirements
Module: alu_cond_ctrl_unit

---
 rtl/alu_cond_ctrl_unit.sv | 208 ++++++++++++++++++++
 tb/tb_alu_cond_ctrl_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cond_ctrl_unit.sv
// SPARC-subset decode, 32-bit ALU with NZVC flags, registered PSR and branch
// condition evaluation. Everything is combinational except the 4-bit PSR.
module alu_cond_ctrl_unit (
  input  logic        Clk,
  input  logic        R,
  input  logic [31:0] ID_instr,
  output logic [15:0] ctrl_word,
  input  logic [3:0]  EX_alu_op,
  input  logic [31:0] EX_A,
  input  logic [31:0] EX_B,
  input  logic        EX_modifyCC,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_flags,
  output logic [3:0]  psr_out,
  input  logic [3:0]  ID_cond,
  input  logic        ID_B_instr,
  output logic        branch_taken
);

  typedef struct packed {
    logic       jmpl;
    logic       rw;
    logic [3:0] alu_op;
    logic       se;
    logic       load;
    logic       rf_en;
    logic [1:0] size;
    logic       mod_cc;
    logic       call;
    logic       dm_en;
    logic       b;
    logic       annul;
  } ctrl_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // ---------------------------------------------------------------- decode
  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic [3:0] arith_op;
  logic       arith_hit;
  ctrl_t      ctrl;

  assign op  = ID_instr[31:30];
  assign op2 = ID_instr[24:22];
  assign op3 = ID_instr[24:19];

  wire unused_instr = ^{ID_instr[28:25], ID_instr[18:0]};

  // op=10 arithmetic/logic table; op3[4] selects the cc variant and is
  // only meaningful for the 0x00-0x1F group, so it is stripped here.
  always_comb begin
    arith_op  = 4'b0000;
    arith_hit = 1'b1;
    case ({op3[5], op3[3:0]})
      5'b0_0000: arith_op = 4'b0000;
      5'b0_1000: arith_op = 4'b0001;
      5'b0_0100: arith_op = 4'b0010;
      5'b0_1100: arith_op = 4'b0011;
      5'b0_0001: arith_op = 4'b0101;
      5'b0_0010: arith_op = 4'b0110;
      5'b0_0011: arith_op = 4'b0111;
      5'b0_0111: arith_op = 4'b1000;
      5'b0_0101: arith_op = 4'b1001;
      5'b0_0110: arith_op = 4'b1010;
      5'b1_0101: arith_op = 4'b1011;
      5'b1_0110: arith_op = 4'b1100;
      5'b1_0111: arith_op = 4'b1101;
      default:   arith_hit = 1'b0;
    endcase
    if (op3[5] && op3[4])
      arith_hit = 1'b0;
  end

  always_comb begin
    ctrl = '0;
    case (op)
      2'b01: begin
        ctrl.call  = 1'b1;
        ctrl.rf_en = 1'b1;
      end
      2'b00: begin
        if (op2 == 3'b010) begin
          ctrl.b     = 1'b1;
          ctrl.annul = ID_instr[29];
        end else if (op2 == 3'b100) begin
          ctrl.rf_en  = 1'b1;
          ctrl.alu_op = 4'b1111;
        end
      end
      2'b10: begin
        if (op3 == 6'b111000) begin
          ctrl.jmpl  = 1'b1;
          ctrl.rf_en = 1'b1;
        end else if (arith_hit) begin
          ctrl.rf_en  = 1'b1;
          ctrl.alu_op = arith_op;
          ctrl.mod_cc = op3[4];
        end
      end
      default: begin
        case (op3)
          6'b000000: begin ctrl.load = 1'b1; ctrl.size = SZ_WORD; end
          6'b000001: begin ctrl.load = 1'b1; ctrl.size = SZ_BYTE; end
          6'b000010: begin ctrl.load = 1'b1; ctrl.size = SZ_HALF; end
          6'b001001: begin ctrl.load = 1'b1; ctrl.size = SZ_BYTE; ctrl.se = 1'b1; end
          6'b001010: begin ctrl.load = 1'b1; ctrl.size = SZ_HALF; ctrl.se = 1'b1; end
          6'b000100: begin ctrl.rw = 1'b1; ctrl.size = SZ_WORD; end
          6'b000101: begin ctrl.rw = 1'b1; ctrl.size = SZ_BYTE; end
          6'b000110: begin ctrl.rw = 1'b1; ctrl.size = SZ_HALF; end
          default: ;
        endcase
        ctrl.rf_en = ctrl.load;
        ctrl.dm_en = ctrl.load | ctrl.rw;
      end
    endcase
  end

  assign ctrl_word = ctrl;

  // ------------------------------------------------------------------- ALU
  logic [32:0] ext;
  logic [31:0] res;
  logic        c_flag;
  logic        v_flag;
  logic        cin;

  assign cin = psr_out[0];

  // ext[32] is carry-out on adds and borrow on subtracts (33-bit wrap).
  always_comb begin
    ext    = '0;
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (EX_alu_op)
      4'b0000, 4'b0001: begin
        ext    = {1'b0, EX_A} + {1'b0, EX_B} + {32'd0, cin & EX_alu_op[0]};
        res    = ext[31:0];
        c_flag = ext[32];
        v_flag = (EX_A[31] == EX_B[31]) && (res[31] != EX_A[31]);
      end
      4'b0010, 4'b0011: begin
        ext    = {1'b0, EX_A} - {1'b0, EX_B} - {32'd0, cin & EX_alu_op[0]};
        res    = ext[31:0];
        c_flag = ext[32];
        v_flag = (EX_A[31] != EX_B[31]) && (res[31] != EX_A[31]);
      end
      4'b0100: begin
        ext    = {1'b0, EX_B} - {1'b0, EX_A};
        res    = ext[31:0];
        c_flag = ext[32];
        v_flag = (EX_B[31] != EX_A[31]) && (res[31] != EX_B[31]);
      end
      4'b0101: res = EX_A & EX_B;
      4'b0110: res = EX_A | EX_B;
      4'b0111: res = EX_A ^ EX_B;
      4'b1000: res = ~(EX_A ^ EX_B);
      4'b1001: res = EX_A & ~EX_B;
      4'b1010: res = EX_A | ~EX_B;
      4'b1011: res = EX_A << EX_B[4:0];
      4'b1100: res = EX_A >> EX_B[4:0];
      4'b1101: res = $unsigned($signed(EX_A) >>> EX_B[4:0]);
      4'b1110: res = EX_A;
      default: res = EX_B;
    endcase
  end

  assign alu_out   = res;
  assign alu_flags = {res[31], (res == 32'd0), v_flag, c_flag};

  // ------------------------------------------------------------------- PSR
  always_ff @(posedge Clk or negedge R) begin
    if (!R)
      psr_out <= 4'b0000;
    else if (EX_modifyCC)
      psr_out <= alu_flags;
  end

  // ---------------------------------------------------------------- branch
  logic [3:0] f;
  logic       cond_base;

  // Flags being written this cycle are forwarded so a cc-setting op and the
  // dependent branch can evaluate together.
  assign f = EX_modifyCC ? alu_flags : psr_out;

  // Upper half of the condition space is the complement of the lower half.
  always_comb begin
    cond_base = 1'b0;
    case (ID_cond[2:0])
      3'd0: cond_base = 1'b0;
      3'd1: cond_base = f[2];
      3'd2: cond_base = f[2] | (f[3] ^ f[1]);
      3'd3: cond_base = f[3] ^ f[1];
      3'd4: cond_base = f[0] | f[2];
      3'd5: cond_base = f[0];
      3'd6: cond_base = f[3];
      default: cond_base = f[1];
    endcase
  end

  assign branch_taken = ID_B_instr & (cond_base ^ ID_cond[3]);

endmodule

// File: tb/tb_alu_cond_ctrl_unit.sv
// Self-checking bench: decode/ALU vector tables, hand-written PSR/reset/branch
// sequences, then randomized ALU+branch traffic against an arithmetic model.
module tb_alu_cond_ctrl_unit;

  logic        Clk;
  logic        R;
  logic [31:0] ID_instr;
  logic [15:0] ctrl_word;
  logic [3:0]  EX_alu_op;
  logic [31:0] EX_A;
  logic [31:0] EX_B;
  logic        EX_modifyCC;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  psr_out;
  logic [3:0]  ID_cond;
  logic        ID_B_instr;
  logic        branch_taken;

  alu_cond_ctrl_unit dut (
    .Clk(Clk), .R(R), .ID_instr(ID_instr), .ctrl_word(ctrl_word),
    .EX_alu_op(EX_alu_op), .EX_A(EX_A), .EX_B(EX_B), .EX_modifyCC(EX_modifyCC),
    .alu_out(alu_out), .alu_flags(alu_flags), .psr_out(psr_out),
    .ID_cond(ID_cond), .ID_B_instr(ID_B_instr), .branch_taken(branch_taken)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flags derived from the numeric value of the exact result.
  task automatic model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit cin, output logic [31:0] r, output logic [3:0] fl);
    longint ua, ub, sa, sb, full, sfull;
    bit arith, is_sub;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    full = 0; sfull = 0; arith = (op <= 4); is_sub = (op >= 2 && op <= 4);
    r = 32'd0;
    case (op)
      0: begin full = ua + ub;           sfull = sa + sb; end
      1: begin full = ua + ub + cin;     sfull = sa + sb + cin; end
      2: begin full = ua - ub;           sfull = sa - sb; end
      3: begin full = ua - ub - cin;     sfull = sa - sb - cin; end
      4: begin full = ub - ua;           sfull = sb - sa; end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = ~(a ^ b);
      9: r = a & ~b;
      10: r = a | ~b;
      11: r = a << b[4:0];
      12: r = a >> b[4:0];
      13: r = 32'(sa >>> b[4:0]);
      14: r = a;
      default: r = b;
    endcase
    if (arith) r = full[31:0];
    fl[3] = r[31];
    fl[2] = (r == 0);
    fl[1] = arith && (sfull > 64'sd2147483647 || sfull < -64'sd2147483648);
    fl[0] = arith && (is_sub ? (full < 0) : (full > 64'hFFFF_FFFF));
  endtask

  function automatic bit model_branch(input bit bi, input logic [3:0] cond, input logic [3:0] fl);
    bit n, z, v, c;
    {n, z, v, c} = fl;
    if (!bi) return 0;
    case (cond)
      4'b0000: return 0;
      4'b1000: return 1;
      4'b0001: return z;
      4'b1001: return !z;
      4'b0010: return z || (n != v);
      4'b1010: return !(z || (n != v));
      4'b0011: return n != v;
      4'b1011: return n == v;
      4'b0100: return c || z;
      4'b1100: return !(c || z);
      4'b0101: return c;
      4'b1101: return !c;
      4'b0110: return n;
      4'b1110: return !n;
      4'b0111: return v;
      default: return !v;
    endcase
  endfunction

  typedef struct { logic [31:0] instr; logic [15:0] ctrl; } dec_vec_t;
  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] r; logic [3:0] fl; } alu_vec_t;

  dec_vec_t dec_tab[$];
  alu_vec_t alu_tab[$];
  logic [3:0] mpsr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    logic [3:0]  ef;
    logic [31:0] specials [6];

    dec_tab = '{
      '{32'h86804002, 16'h0090}, '{32'hC6004002, 16'h01C4}, '{32'h22800003, 16'h0003},
      '{32'h00000000, 16'h0000}, '{32'h40000010, 16'h0088}, '{32'h01000000, 16'h3C80},
      '{32'h10800002, 16'h0002}, '{32'h80200000, 16'h0880}, '{32'h81280000, 16'h2C80},
      '{32'h81380000, 16'h3480}, '{32'h80B80000, 16'h2090}, '{32'h81C00000, 16'h8080},
      '{32'h80480000, 16'h0000}, '{32'h81800000, 16'h0000}, '{32'h81A80000, 16'h0000},
      '{32'hC0500000, 16'h03A4}, '{32'hC0280000, 16'h4004}, '{32'hC0200000, 16'h4044},
      '{32'hC0080000, 16'h0184}, '{32'hC0180000, 16'h0000}, '{32'h01800000, 16'h0000}
    };
    alu_tab = '{
      '{4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1010},
      '{4'h2, 32'h5,        32'h5, 32'h00000000, 4'b0100},
      '{4'hD, 32'h80000000, 32'h4, 32'hF8000000, 4'b1000},
      '{4'hC, 32'h80000000, 32'h4, 32'h08000000, 4'b0000},
      '{4'h2, 32'h0,        32'h1, 32'hFFFFFFFF, 4'b1001},
      '{4'h4, 32'h3,        32'h1, 32'hFFFFFFFE, 4'b1001}
    };
    specials = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};

    // Reset held through an edge with modifyCC=1: PSR must stay clear.
    R = 1'b0; ID_instr = '0; EX_alu_op = 4'h0; EX_A = 32'hFFFFFFFF; EX_B = 32'h1;
    EX_modifyCC = 1'b1; ID_cond = '0; ID_B_instr = 1'b0;
    #2 chk("reset_psr", 32'(psr_out), 32'h0);
    @(posedge Clk); #1;
    chk("reset_edge_psr", 32'(psr_out), 32'h0);
    EX_modifyCC = 1'b0; R = 1'b1;

    foreach (dec_tab[i]) begin
      ID_instr = dec_tab[i].instr;
      #1 chk($sformatf("decode_%h", dec_tab[i].instr), 32'(ctrl_word), 32'(dec_tab[i].ctrl));
    end

    @(negedge Clk);
    foreach (alu_tab[i]) begin
      EX_alu_op = alu_tab[i].op; EX_A = alu_tab[i].a; EX_B = alu_tab[i].b;
      #1;
      chk($sformatf("alu_tab%0d_out", i), alu_out, alu_tab[i].r);
      chk($sformatf("alu_tab%0d_flags", i), 32'(alu_flags), 32'(alu_tab[i].fl));
    end

    // PSR load, then add-with-carry consumes C from the PSR.
    @(negedge Clk);
    EX_alu_op = 4'h0; EX_A = 32'hFFFFFFFF; EX_B = 32'h1; EX_modifyCC = 1'b1;
    @(posedge Clk); #1;
    EX_modifyCC = 1'b0;
    chk("psr_load", 32'(psr_out), 32'b0101);
    EX_alu_op = 4'h1; EX_A = 32'h0; EX_B = 32'h0;
    #1 chk("addx_cin", alu_out, 32'h1);
    @(posedge Clk); #1;
    chk("psr_hold", 32'(psr_out), 32'b0101);

    // Branch evaluation from PSR and from forwarded flags.
    @(negedge Clk);
    ID_B_instr = 1'b1; ID_cond = 4'b0001;
    #1 chk("br_be_psr", 32'(branch_taken), 32'h1);
    ID_cond = 4'b1001;
    #1 chk("br_bne_psr", 32'(branch_taken), 32'h0);
    ID_B_instr = 1'b0; ID_cond = 4'b0001;
    #1 chk("br_none", 32'(branch_taken), 32'h0);
    ID_B_instr = 1'b1; EX_alu_op = 4'h0; EX_A = 32'h1; EX_B = 32'h1; EX_modifyCC = 1'b1;
    #1 chk("br_be_fwd", 32'(branch_taken), 32'h0);
    EX_modifyCC = 1'b0; ID_B_instr = 1'b0;

    // Asynchronous reset mid-cycle.
    @(negedge Clk);
    R = 1'b0;
    #1 chk("async_reset", 32'(psr_out), 32'h0);
    @(negedge Clk);
    R = 1'b1;
    mpsr = 4'b0000;

    for (int it = 0; it < 400; it++) begin
      @(negedge Clk);
      EX_alu_op   = 4'($urandom_range(0, 15));
      EX_A        = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      EX_B        = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      EX_modifyCC = 1'($urandom_range(0, 1));
      ID_B_instr  = 1'($urandom_range(0, 1));
      ID_cond     = 4'($urandom_range(0, 15));
      #1;
      model_alu(EX_alu_op, EX_A, EX_B, mpsr[0], er, ef);
      chk($sformatf("rnd%0d_out", it), alu_out, er);
      chk($sformatf("rnd%0d_flags", it), 32'(alu_flags), 32'(ef));
      chk($sformatf("rnd%0d_br", it), 32'(branch_taken),
          32'(model_branch(ID_B_instr, ID_cond, EX_modifyCC ? ef : mpsr)));
      @(posedge Clk); #1;
      if (EX_modifyCC) mpsr = ef;
      chk($sformatf("rnd%0d_psr", it), 32'(psr_out), 32'(mpsr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
